// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack port, stall, byte steering.
// Optional access timeout enabled with `define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  StSrcM,
  input  logic                  LdSrcM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MemErrM
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state;

  logic       is_st;
  logic       is_ld;
  logic       pending;
  logic [3:0] be_st;
  logic       ld_byte_q;
  logic [1:0] lane_q;
  logic [7:0] rbyte;

  assign is_st   = MemWriteM;
  assign is_ld   = (ResultSrcM == 2'b01);
  assign pending = is_st | is_ld;
  assign be_st   = StSrcM ? (4'b0001 << ALUResultM[1:0]) : 4'hF;
  assign rbyte   = mem_rdata[{lane_q, 3'b000} +: 8];

  assign StallM = ((state == IDLE) && pending) || (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign MemErrM    = 1'b0;
`endif

  // Access sequencer: launches the request, waits for ack, returns data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
      ReadDataM <= '0;
      ld_byte_q <= 1'b0;
      lane_q    <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      MemErrM   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      MemErrM <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pending) begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_be    <= is_st ? be_st : 4'hF;
            mem_wdata <= (is_st && StSrcM) ?
                         {4{WriteDataM[7:0]}} : WriteDataM;
            ld_byte_q <= ~is_st & LdSrcM;
            lane_q    <= ALUResultM[1:0];
`ifdef MEM_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we)
              ReadDataM <= ld_byte_q ?
                {{(DATA_WIDTH-8){1'b0}}, rbyte} : mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == LAST) begin
            state   <= DONE;
            mem_req <= 1'b0;
            MemErrM <= 1'b1;
            if (!mem_we)
              ReadDataM <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus
// back-to-back, reset-abort and long-wait/timeout sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic        StSrcM;
  logic        LdSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MemErrM;

  mem_access_ctrl #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM),
    .StSrcM(StSrcM),
    .LdSrcM(LdSrcM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM),
    .StallM(StallM),
    .MemErrM(MemErrM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  rs;
    logic        st;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackn;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_stall;
    logic [31:0] e_rd;
  } vec_t;

  // Present one instruction in MEM and play the memory side until
  // the pipeline advances. ack_c/req_c are cycle stamps (-1 if none).
  task automatic run_op(input vec_t v, input string tag,
                        output int ack_c, output int req_c);
    int stalls;
    int seen;
    stalls = 0;
    seen   = 0;
    ack_c  = -1;
    req_c  = -1;
    MemWriteM  = v.we;
    ResultSrcM = v.rs;
    StSrcM     = v.st;
    LdSrcM     = v.ld;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    mem_rdata  = v.rdata;
    mem_ack    = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (StallM) stalls++;
      if (mem_req) begin
        seen++;
        if (req_c < 0) req_c = cyc;
        chk({tag, " addr"}, mem_addr, v.e_addr);
        chk({tag, " be"}, {28'h0, mem_be}, {28'h0, v.e_be});
        chk({tag, " we"}, {31'h0, mem_we}, {31'h0, v.e_we});
        if (v.e_we)
          chk({tag, " wdata"}, mem_wdata, v.e_wdata);
        if (seen == v.ackn) begin
          mem_ack = 1'b1;
          ack_c   = cyc;
        end
      end
      if (!StallM) begin
        chk({tag, " stalls"}, stalls, v.e_stall);
        chk({tag, " req_done"}, {31'h0, mem_req}, 32'h0);
        chk({tag, " rdata"}, ReadDataM, v.e_rd);
        chk({tag, " err"}, {31'h0, MemErrM}, 32'h0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    chk({tag, " cycle_budget"}, 32'h1, 32'h0);
  endtask

  task automatic idle_inputs();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    StSrcM     = 1'b0;
    LdSrcM     = 1'b0;
    mem_ack    = 1'b0;
  endtask

  vec_t tbl[13];
  vec_t v;
  int   a0, r0, a1, r1, a2, r2;
  int   n_req, n_err, n_stall;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          we  rs    st  ld  addr          wdata         rdata        ack
    //          e_addr        be    we  e_wdata       stall  e_rd
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0050, 32'h0, 32'h0, 0,
                32'h0, 4'h0, 1'b0, 32'h0, 0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0104, 32'h0,
                32'hDEAD_BEEF, 1,
                32'h0000_0104, 4'hF, 1'b0, 32'h0, 2, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0203, 32'h1234_56A5,
                32'h0, 3,
                32'h0000_0200, 4'b1000, 1'b1, 32'hA5A5_A5A5, 4,
                32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_1002, 32'h0,
                32'h11F2_3344, 2,
                32'h0000_1000, 4'hF, 1'b0, 32'h0, 3, 32'h0000_00F2};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0301, 32'hCAFE_F00D,
                32'h0, 2,
                32'h0000_0300, 4'hF, 1'b1, 32'hCAFE_F00D, 3,
                32'h0000_00F2};
    tbl[5]  = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_005A,
                32'h0, 1,
                32'h0000_0010, 4'b0001, 1'b1, 32'h5A5A_5A5A, 2,
                32'h0000_00F2};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_2007, 32'h0,
                32'h11F2_3344, 1,
                32'h0000_2004, 4'hF, 1'b0, 32'h0, 2, 32'h0000_0011};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_2001, 32'h0,
                32'h11F2_3344, 4,
                32'h0000_2000, 4'hF, 1'b0, 32'h0, 5, 32'h0000_0033};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_2000, 32'h0,
                32'hA0B0_C0D0, 1,
                32'h0000_2000, 4'hF, 1'b0, 32'h0, 2, 32'h0000_00D0};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0400, 32'h0BAD_F00D,
                32'hFFFF_FFFF, 1,
                32'h0000_0400, 4'hF, 1'b1, 32'h0BAD_F00D, 2,
                32'h0000_00D0};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0404, 32'h0,
                32'hFFFF_FFFF, 0,
                32'h0, 4'h0, 1'b0, 32'h0, 0, 32'h0000_00D0};
    tbl[11] = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0002, 32'h0,
                32'h89AB_CDEF, 2,
                32'h0000_0000, 4'hF, 1'b0, 32'h0, 3, 32'h89AB_CDEF};
    tbl[12] = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0005, 32'hFFFF_FF3C,
                32'h0, 2,
                32'h0000_0004, 4'b0010, 1'b1, 32'h3C3C_3C3C, 3,
                32'h89AB_CDEF};

    idle_inputs();
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    mem_rdata  = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", {31'h0, mem_req}, 32'h0);
    chk("rst we", {31'h0, mem_we}, 32'h0);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst be", {28'h0, mem_be}, 32'h0);
    chk("rst rdata", ReadDataM, 32'h0);
    chk("rst err", {31'h0, MemErrM}, 32'h0);
    chk("rst stall", {31'h0, StallM}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i], $sformatf("v%0d", i), a0, r0);

    // ALU then two loads back to back: the second request goes high
    // on the second clock edge after the edge that samples the ack,
    // i.e. three cycle stamps after the ack cycle.
    v = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0,
          32'h0, 4'h0, 1'b0, 32'h0, 0, 32'h89AB_CDEF};
    run_op(v, "b2b alu", a0, r0);
    v = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0800, 32'h0,
          32'h0102_0304, 1,
          32'h0000_0800, 4'hF, 1'b0, 32'h0, 2, 32'h0102_0304};
    run_op(v, "b2b ld1", a1, r1);
    v = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_0805, 32'h0,
          32'h0506_0708, 2,
          32'h0000_0804, 4'hF, 1'b0, 32'h0, 3, 32'h0000_0007};
    run_op(v, "b2b ld2", a2, r2);
    chk("b2b req_gap", r2 - a1, 3);

    // Reset in the second ACCESS cycle, ack arrives after reset
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    LdSrcM     = 1'b0;
    ALUResultM = 32'h0000_0500;
    mem_rdata  = 32'h7777_7777;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rsta req_before", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rsta req", {31'h0, mem_req}, 32'h0);
    chk("rsta stall", {31'h0, StallM}, 32'h0);
    chk("rsta rdata", ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rsta late_ack rdata", ReadDataM, 32'h0);
    chk("rsta late_ack req", {31'h0, mem_req}, 32'h0);
    @(posedge clk);
    #1;

    v = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0600, 32'h0,
          32'h1357_9BDF, 1,
          32'h0000_0600, 4'hF, 1'b0, 32'h0, 2, 32'h1357_9BDF};
    run_op(v, "prime", a0, r0);

`ifdef MEM_TIMEOUT_EN
    // Ack on the last permitted cycle is a normal completion
    v = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0610, 32'h0,
          32'h2468_ACE0, 4,
          32'h0000_0610, 4'hF, 1'b0, 32'h0, 5, 32'h2468_ACE0};
    run_op(v, "tmo edge", a0, r0);
    // No ack: request held 4 cycles, then one error pulse
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    LdSrcM     = 1'b0;
    ALUResultM = 32'h0000_0620;
    mem_rdata  = 32'hFFFF_FFFF;
    mem_ack    = 1'b0;
    n_req = 0;
    n_err = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req) n_req++;
      if (MemErrM) begin
        n_err++;
        chk("tmo rdata", ReadDataM, 32'h0);
        chk("tmo stall", {31'h0, StallM}, 32'h0);
        idle_inputs();
      end
      @(posedge clk);
      #1;
    end
    chk("tmo req_cycles", n_req, 4);
    chk("tmo err_pulses", n_err, 1);
`else
    // No ack for a long time: stall holds with no error
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    LdSrcM     = 1'b0;
    ALUResultM = 32'h0000_0620;
    mem_rdata  = 32'hFEED_FACE;
    mem_ack    = 1'b0;
    n_stall = 0;
    n_req   = 0;
    n_err   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (StallM) n_stall++;
      if (mem_req) n_req++;
      if (MemErrM) n_err++;
      @(posedge clk);
      #1;
    end
    chk("wait stall", n_stall, 20);
    chk("wait req", n_req, 19);
    chk("wait err", n_err, 0);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("wait done stall", {31'h0, StallM}, 32'h0);
    chk("wait done rdata", ReadDataM, 32'hFEED_FACE);
    idle_inputs();
`endif

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for data-memory accesses in the MEM stage of the pipelined RV32I core. Takes the load/store controls and address/data held in the EX/MEM pipeline register, drives a variable-latency req/ack data-memory port, and asserts a stall that freezes all upstream pipeline registers until the access completes. It also does byte-lane steering for byte loads/stores and returns aligned read data to the writeback path.

## Interface
- DATA_WIDTH, 32, datapath/address width (only 32 supported)
- TIMEOUT_CYCLES, 16, max cycles in ACCESS before abort (used only with MEM_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- MemWriteM  in  1  store in MEM stage
- ResultSrcM  in  2  2'b01 = load in MEM stage
- StSrcM  in  1  1 = byte store, 0 = word store
- LdSrcM  in  1  1 = byte load (zero-extended), 0 = word load
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data
- mem_req  out  1  access request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  {ALUResultM[31:2],2'b00}
- mem_wdata  out  32  steered store data
- mem_be  out  4  byte enables
- mem_ack  in  1  access complete (one-cycle pulse)
- mem_rdata  in  32  read word, valid with mem_ack
- ReadDataM  out  32  load result to writeback mux
- StallM  out  1  freeze PC and all pipeline registers up to and including EX/MEM
- MemErrM  out  1  access aborted by timeout

## Operation
- Access pending = MemWriteM | (ResultSrcM == 2'b01). If both, the store takes priority.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if pending, go to ACCESS. Otherwise stay.
  - ACCESS: on mem_ack, go to DONE and capture the result into ReadDataM.
  - DONE: always return to IDLE.
- StallM (combinational) = (IDLE & pending) | ACCESS. It is 0 in DONE, so the pipeline advances at the end of DONE.
- mem_req, mem_we, mem_addr, mem_wdata, mem_be are registered. Set on the IDLE→ACCESS edge, held constant through ACCESS, mem_req cleared on leaving ACCESS.
- Word store: mem_be = 4'hF, mem_wdata = WriteDataM.
- Byte store: mem_be = 4'b0001 << ALUResultM[1:0], mem_wdata = {4{WriteDataM[7:0]}}.
- Loads: mem_we = 0, mem_be = 4'hF.
- Word load: ReadDataM = mem_rdata.
- Byte load: ReadDataM = zero-extended mem_rdata byte at lane ALUResultM[1:0].
- For a store, ReadDataM is unchanged.
- Address bits [1:0] are dropped for word accesses; misalignment is not checked.
- mem_ack in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, ReadDataM 0, MemErrM 0, timeout counter 0.
- Non-memory instruction: zero stall cycles.
- Memory instruction with ack N cycles after mem_req rises (N≥1) occupies MEM for N+2 cycles:
  - cycle 0: IDLE, stall
  - cycles 1..N: ACCESS, stall
  - cycle N+1: DONE, no stall
- ReadDataM is valid throughout DONE and holds until the next load completes.
- Back-to-back memory instructions: IDLE follows DONE, so the next access starts one cycle later. No request overlap.
- rst in any state returns to IDLE on the next edge and drops mem_req. A late mem_ack is ignored. rst wins over a simultaneous mem_ack.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES, go to DONE and drop mem_req.
  - On that DONE, ReadDataM = 0 for a load, and MemErrM = 1 for the DONE cycle only.
  - An ack in the same cycle as expiry counts as a normal completion.
- MEM_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely.
  - MemErrM tied to 0.

## Test plan
- Word load, addr 0x0000_0104, ack 1 cycle after req, rdata 0xDEADBEEF:
  - mem_addr 0x104; StallM high 2 cycles; ReadDataM 0xDEADBEEF in DONE.
- Byte store, addr 0x0000_0203, WriteDataM 0x1234_56A5, ack after 3 cycles:
  - mem_be 4'b1000, mem_wdata 0xA5A5A5A5, mem_we 1, StallM high 4 cycles.
- Byte load, addr 0x...02, rdata 0x11F2_3344:
  - ReadDataM 0x0000_00F2.
- ALU instruction followed by two back-to-back loads:
  - ALU: no stall.
  - Loads: second mem_req rises exactly 2 cycles after the first load's ack.
- rst asserted in the second ACCESS cycle, ack one cycle later:
  - mem_req 0 after the reset edge; ReadDataM stays 0; StallM 0.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - mem_req drops after 4 cycles; MemErrM pulses once; ReadDataM 0.
- Without MEM_TIMEOUT_EN, same stimulus:
  - StallM remains 1 until ack.
